bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Initiator end of the serial bit-level bus. A local requester hands it one address/data command.
- It requests the bus from the arbiter, then shifts the 15-bit address out serially and waits for the slave's address acknowledge.
- For a write, it shifts out 8 data bits and waits for the write acknowledge. For a read, it shifts in 8 data bits.
- It then returns the result to the local side.

Parameters:
- ADDR_W, 15, serial address frame length (bits)
- DATA_W, 8, data frame length (bits)
- READ_LAT, 1, cycles after entering READ before the first valid B_BUS_IN bit
- TIMEOUT, 15, maximum cycles waited for B_GRANT or any B_ACK before abort

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- M_EXECUTE  in  1  one-cycle start pulse; sampled only in IDLE
- M_RW  in  1  1 = write, 0 = read (matches the B_RW encoding)
- M_ADDR  in  ADDR_W  transaction address
- M_DIN  in  DATA_W  write data
- M_BUSY  out  1  high whenever state != IDLE
- M_DVALID  out  1  one-cycle pulse: transaction finished OK; M_DOUT valid (read)
- M_DOUT  out  DATA_W  read data, held until the next read completes
- M_ERR  out  1  one-cycle pulse: transaction aborted by timeout
- B_REQUEST  out  1  bus request to arbiter
- B_GRANT  in  1  arbiter grant
- B_UTIL  out  1  bus in use; drives slave select decoding (AD_SEL)
- B_RW  out  1  direction, held for the whole transaction
- B_BUS_OUT  out  1  serial master-to-slave line
- B_BUS_IN  in  1  serial slave-to-master line
- B_ACK  in  1  slave acknowledge
- B_READY  in  1  slave ready (informational; latched into status only)
- B_SBSY  in  1  slave busy (informational)

Behaviour:
- Reset (synchronous, RST=1 at posedge): state = IDLE.
  - All outputs 0: M_BUSY, M_DVALID, M_ERR, B_REQUEST, B_UTIL, B_RW, B_BUS_OUT.
  - M_DOUT = 0; internal shift registers and counters cleared.
  - Reset mid-transaction aborts immediately with no M_ERR pulse.
- M_ADDR, M_DIN and M_RW are latched on the accepted M_EXECUTE. Later changes are ignored. M_EXECUTE outside IDLE is ignored.
- States:
  - IDLE: on M_EXECUTE, latch command → REQ.
  - REQ: B_REQUEST=1. B_GRANT=1 → ADDR. After TIMEOUT cycles without grant → ABORT.
  - ADDR: B_UTIL=1; B_RW=latched RW. B_BUS_OUT = addr[k] in cycle k, k=0..ADDR_W-1, LSB first. After ADDR_W cycles → ADDR_ACK.
  - ADDR_ACK: B_UTIL=1; B_BUS_OUT=0. B_ACK=1 → WRITE if RW=1, else READ. No ack in TIMEOUT cycles → ABORT.
  - WRITE: B_BUS_OUT = data[k] in cycle k, k=0..DATA_W-1, LSB first. → WR_ACK.
  - WR_ACK: wait for B_ACK high, then B_ACK low, then → DONE. Timeout → ABORT.
  - READ: skip READ_LAT cycles. Then sample B_BUS_IN into bit k over DATA_W consecutive cycles, LSB first. → DONE.
  - DONE: M_DVALID=1 for one cycle. For a read, M_DOUT updates in the same cycle. → IDLE.
  - ABORT: M_ERR=1 for one cycle → IDLE.
- B_REQUEST:
  - Asserted from the REQ entry cycle.
  - Held through DONE/ABORT; deasserted on return to IDLE.
- B_UTIL:
  - Rises the cycle ADDR is entered.
  - Falls on entry to DONE/ABORT.
  - Always contiguous.
- Grant loss: if B_GRANT drops during ADDR..READ, the transaction continues; the arbiter must not revoke mid-transfer.
- B_ACK simultaneous with the timeout expiry cycle: the ack wins.
- Timeout counters restart on each wait-state entry. A counter reaching TIMEOUT-1 without the awaited event → ABORT on the next edge.
- Latency, write, zero-wait grant/ack: EXECUTE→DVALID = 1 + 1 + ADDR_W + 1 + DATA_W + WR_ACK + 1 cycles.
- Back-to-back: a new M_EXECUTE is accepted in the IDLE cycle directly after DONE.

Decomposition:
- Package bus_pkg holds:
  - state enum {IDLE, REQ, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, DONE, ABORT}
  - ADDR_W, DATA_W
  - RW_READ=0, RW_WRITE=1
- Reuse the existing counter module (rst, CLK, incr, count) twice:
  - bit counter for ADDR/WRITE/READ
  - timeout counter for REQ/ACK waits
- No new sub-module.

Test Plan:
- Write, addr 0x0A5A, data 0xC3, grant after 2 cycles, acks immediate:
  - B_BUS_OUT shows 0x0A5A LSB-first over 15 cycles, then 1,1,0,0,0,0,1,1.
  - M_DVALID pulses once; M_ERR stays 0.
- Read, addr 0x0002, slave model returns 0xAD with READ_LAT=1:
  - M_DOUT=0xAD in the M_DVALID cycle; B_RW=0 throughout.
- No grant for 15 cycles:
  - M_ERR pulses once; B_UTIL never rises; returns to IDLE; B_REQUEST drops.
- No address ack:
  - M_ERR after ADDR_W+TIMEOUT cycles post-grant; no WRITE/READ bits driven.
- RST=1 asserted in mid-WRITE (bit 4):
  - Next cycle all outputs 0, state IDLE, no M_ERR/M_DVALID.
  - Subsequent read completes normally.
- Two back-to-back EXECUTEs (write 0x11, then read):
  - Second accepted the cycle after DONE.
  - A second EXECUTE pulsed while busy is ignored; exactly two M_DVALID pulses.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and frame constants for the serial bit-level bus.
package bus_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    ADDR,
    ADDR_ACK,
    WRITE,
    WR_ACK,
    READ,
    DONE,
    ABORT
  } state_t;

endpackage

// File: rtl/counter.sv
// Free-running up-counter with synchronous clear; shared by bit and timeout counting.
module counter #(
  parameter int W = 4
) (
  input  logic         rst,
  input  logic         CLK,
  input  logic         incr,
  output logic [W-1:0] count
);

  // Clear has priority over increment.
  always_ff @(posedge CLK) begin
    if (rst) begin
      count <= '0;
    end else if (incr) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// Initiator side of the serial bus: request, address frame, data frame, result.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for M_EXECUTE; command latched on acceptance
// REQ      | B_REQUEST high, waiting for B_GRANT (timeout -> ABORT)
// ADDR     | shifting address out LSB first, one bit per cycle
// ADDR_ACK | waiting for slave address acknowledge (timeout -> ABORT)
// WRITE    | shifting write data out LSB first
// WR_ACK   | waiting for B_ACK high then low (timeout -> ABORT)
// READ     | READ_LAT idle cycles, then shifting read data in LSB first
// DONE     | M_DVALID pulse, M_DOUT updated on reads
// ABORT    | M_ERR pulse
module bus_master_port
  import bus_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              M_EXECUTE,
  input  logic              M_RW,
  input  logic [ADDR_W-1:0] M_ADDR,
  input  logic [DATA_W-1:0] M_DIN,
  output logic              M_BUSY,
  output logic              M_DVALID,
  output logic [DATA_W-1:0] M_DOUT,
  output logic              M_ERR,
  output logic              B_REQUEST,
  input  logic              B_GRANT,
  output logic              B_UTIL,
  output logic              B_RW,
  output logic              B_BUS_OUT,
  input  logic              B_BUS_IN,
  input  logic              B_ACK,
  input  logic              B_READY,
  input  logic              B_SBSY
);

  localparam int RD_BITS = READ_LAT + DATA_W;
  localparam int BIT_MAX = (ADDR_W > RD_BITS) ? ADDR_W : RD_BITS;
  localparam int BIT_W   = $clog2(BIT_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_W - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] RD_FIRST  = BIT_W'(READ_LAT);
  localparam logic [BIT_W-1:0] RD_LAST   = BIT_W'(RD_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  state_t              state;
  logic [ADDR_W-1:0]   addr_sh;
  logic [DATA_W-1:0]   data_sh;
  logic                ack_seen;
  logic [1:0]          slave_status_unused;

  logic                bit_incr;
  logic                bit_clr;
  logic [BIT_W-1:0]    bit_cnt;
  logic                tmo_incr;
  logic                tmo_clr;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                tmo_done;

  // Both counters sit at zero outside their states, so every entry restarts them.
  assign bit_incr = (state == ADDR) || (state == WRITE) || (state == READ);
  assign bit_clr  = RST || !bit_incr;
  assign tmo_incr = (state == REQ) || (state == ADDR_ACK) || (state == WR_ACK);
  assign tmo_clr  = RST || !tmo_incr;
  assign tmo_done = (tmo_cnt >= TMO_LAST);

  counter #(.W(BIT_W)) u_bit_cnt (
    .rst   (bit_clr),
    .CLK   (CLK),
    .incr  (bit_incr),
    .count (bit_cnt)
  );

  counter #(.W(TMO_W)) u_tmo_cnt (
    .rst   (tmo_clr),
    .CLK   (CLK),
    .incr  (tmo_incr),
    .count (tmo_cnt)
  );

  // Slave ready/busy are informational only; kept as a status snapshot.
  always_ff @(posedge CLK) begin
    if (RST) slave_status_unused <= '0;
    else     slave_status_unused <= {B_READY, B_SBSY};
  end

  // Transaction sequencer; all bus and local outputs registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      M_BUSY    <= 1'b0;
      M_DVALID  <= 1'b0;
      M_DOUT    <= '0;
      M_ERR     <= 1'b0;
      B_REQUEST <= 1'b0;
      B_UTIL    <= 1'b0;
      B_RW      <= 1'b0;
      B_BUS_OUT <= 1'b0;
      addr_sh   <= '0;
      data_sh   <= '0;
      ack_seen  <= 1'b0;
    end else begin
      M_DVALID <= 1'b0;
      M_ERR    <= 1'b0;
      case (state)
        IDLE: begin
          if (M_EXECUTE) begin
            addr_sh   <= M_ADDR;
            data_sh   <= M_DIN;
            B_RW      <= M_RW;
            M_BUSY    <= 1'b1;
            B_REQUEST <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (B_GRANT) begin
            B_UTIL    <= 1'b1;
            B_BUS_OUT <= addr_sh[0];
            addr_sh   <= addr_sh >> 1;
            state     <= ADDR;
          end else if (tmo_done) begin
            M_ERR <= 1'b1;
            state <= ABORT;
          end
        end
        ADDR: begin
          if (bit_cnt == ADDR_LAST) begin
            B_BUS_OUT <= 1'b0;
            state     <= ADDR_ACK;
          end else begin
            B_BUS_OUT <= addr_sh[0];
            addr_sh   <= addr_sh >> 1;
          end
        end
        ADDR_ACK: begin
          if (B_ACK) begin
            if (B_RW == RW_WRITE) begin
              B_BUS_OUT <= data_sh[0];
              data_sh   <= data_sh >> 1;
              state     <= WRITE;
            end else begin
              state <= READ;
            end
          end else if (tmo_done) begin
            B_UTIL <= 1'b0;
            M_ERR  <= 1'b1;
            state  <= ABORT;
          end
        end
        WRITE: begin
          if (bit_cnt == DATA_LAST) begin
            B_BUS_OUT <= 1'b0;
            ack_seen  <= 1'b0;
            state     <= WR_ACK;
          end else begin
            B_BUS_OUT <= data_sh[0];
            data_sh   <= data_sh >> 1;
          end
        end
        WR_ACK: begin
          if (ack_seen && !B_ACK) begin
            B_UTIL   <= 1'b0;
            M_DVALID <= 1'b1;
            state    <= DONE;
          end else if (!ack_seen && B_ACK) begin
            ack_seen <= 1'b1;
          end else if (tmo_done) begin
            B_UTIL <= 1'b0;
            M_ERR  <= 1'b1;
            state  <= ABORT;
          end
        end
        READ: begin
          if (bit_cnt >= RD_FIRST) begin
            data_sh <= {B_BUS_IN, data_sh[DATA_W-1:1]};
          end
          if (bit_cnt == RD_LAST) begin
            M_DOUT   <= {B_BUS_IN, data_sh[DATA_W-1:1]};
            B_UTIL   <= 1'b0;
            M_DVALID <= 1'b1;
            state    <= DONE;
          end
        end
        DONE, ABORT: begin
          M_BUSY    <= 1'b0;
          B_REQUEST <= 1'b0;
          B_RW      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Randomized bench: per transaction an expected cycle timeline is built from the
// protocol rules, then replayed against the port while acting as arbiter and slave.
module tb_bus_master_port;
  import bus_pkg::*;

  localparam int TMO  = 15;
  localparam int RLAT = 1;
  localparam int MAXC = 128;

  logic              CLK = 1'b0;
  logic              RST;
  logic              M_EXECUTE;
  logic              M_RW;
  logic [ADDR_W-1:0] M_ADDR;
  logic [DATA_W-1:0] M_DIN;
  logic              M_BUSY;
  logic              M_DVALID;
  logic [DATA_W-1:0] M_DOUT;
  logic              M_ERR;
  logic              B_REQUEST;
  logic              B_GRANT;
  logic              B_UTIL;
  logic              B_RW;
  logic              B_BUS_OUT;
  logic              B_BUS_IN;
  logic              B_ACK;
  logic              B_READY;
  logic              B_SBSY;

  always #5 CLK = ~CLK;

  bus_master_port #(.READ_LAT(RLAT), .TIMEOUT(TMO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .M_EXECUTE (M_EXECUTE),
    .M_RW      (M_RW),
    .M_ADDR    (M_ADDR),
    .M_DIN     (M_DIN),
    .M_BUSY    (M_BUSY),
    .M_DVALID  (M_DVALID),
    .M_DOUT    (M_DOUT),
    .M_ERR     (M_ERR),
    .B_REQUEST (B_REQUEST),
    .B_GRANT   (B_GRANT),
    .B_UTIL    (B_UTIL),
    .B_RW      (B_RW),
    .B_BUS_OUT (B_BUS_OUT),
    .B_BUS_IN  (B_BUS_IN),
    .B_ACK     (B_ACK),
    .B_READY   (B_READY),
    .B_SBSY    (B_SBSY)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // expected outputs and planned inputs, one entry per cycle of a transaction
  logic              e_busy[MAXC], e_req[MAXC], e_util[MAXC], e_out[MAXC];
  logic              e_dv[MAXC], e_err[MAXC];
  logic [DATA_W-1:0] e_dout[MAXC];
  logic              p_grant[MAXC], p_ack[MAXC], p_bin[MAXC], p_exec[MAXC];
  int                n_cyc;
  logic              cur_rw;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_din;
  logic [DATA_W-1:0] model_dout = '0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic push(input logic busy, req, util, out, dv, err, grant, ack, bin, exec);
    e_busy[n_cyc]  = busy;
    e_req[n_cyc]   = req;
    e_util[n_cyc]  = util;
    e_out[n_cyc]   = out;
    e_dv[n_cyc]    = dv;
    e_err[n_cyc]   = err;
    e_dout[n_cyc]  = model_dout;
    p_grant[n_cyc] = grant;
    p_ack[n_cyc]   = ack;
    p_bin[n_cyc]   = bin;
    p_exec[n_cyc]  = exec;
    n_cyc++;
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // g/a: grant and address-ack delay (>= TMO means never); h<0: no write ack;
  // write ack is high for hl cycles starting h cycles into the wait.
  task automatic build(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] din,
                       input logic [DATA_W-1:0] rdat, input int g, input int a, input int h, input int hl);
    n_cyc = 0; cur_rw = rw; cur_addr = addr; cur_din = din;
    push(0, 0, 0, 0, 0, 0, 0, 0, rb(), 1);
    for (int r = 0; r < TMO; r++) begin
      push(1, 1, 0, 0, 0, 0, logic'(r == g), 0, rb(), 0);
      if (r == g) break;
    end
    if (g >= TMO) begin
      push(1, 1, 0, 0, 0, 1, 0, 0, rb(), 0);
      return;
    end
    for (int k = 0; k < ADDR_W; k++) push(1, 1, 1, addr[k], 0, 0, rb(), 0, rb(), 0);
    for (int r = 0; r < TMO; r++) begin
      push(1, 1, 1, 0, 0, 0, rb(), logic'(r == a), rb(), 0);
      if (r == a) break;
    end
    if (a >= TMO) begin
      push(1, 1, 0, 0, 0, 1, 0, 0, rb(), 0);
      return;
    end
    if (rw) begin
      for (int k = 0; k < DATA_W; k++) push(1, 1, 1, din[k], 0, 0, rb(), 0, rb(), 0);
      if (h < 0) begin
        for (int r = 0; r < TMO; r++) push(1, 1, 1, 0, 0, 0, rb(), 0, rb(), 0);
        push(1, 1, 0, 0, 0, 1, 0, 0, rb(), 0);
        return;
      end
      for (int r = 0; r <= h + hl; r++)
        push(1, 1, 1, 0, 0, 0, rb(), logic'(r >= h && r < h + hl), rb(), 0);
    end else begin
      for (int c = 0; c < RLAT + DATA_W; c++)
        push(1, 1, 1, 0, 0, 0, rb(), 0, (c >= RLAT) ? rdat[c-RLAT] : rb(), 0);
      model_dout = rdat;
    end
    push(1, 1, 0, 0, 1, 0, 0, 0, rb(), 0);
  endtask

  task automatic check_idle_outputs();
    chk_eq("busy", M_BUSY, 0);
    chk_eq("req", B_REQUEST, 0);
    chk_eq("util", B_UTIL, 0);
    chk_eq("rw", B_RW, 0);
    chk_eq("bus_out", B_BUS_OUT, 0);
    chk_eq("dvalid", M_DVALID, 0);
    chk_eq("err", M_ERR, 0);
    chk_eq("dout", M_DOUT, model_dout);
  endtask

  task automatic drive_junk();
    M_EXECUTE = 1'b0;
    M_RW      = rb();
    M_ADDR    = ADDR_W'($urandom);
    M_DIN     = DATA_W'($urandom);
    B_GRANT   = 1'b0;
    B_ACK     = 1'b0;
    B_BUS_IN  = rb();
    B_READY   = rb();
    B_SBSY    = rb();
  endtask

  task automatic idle(input int nc);
    for (int i = 0; i < nc; i++) begin
      @(negedge CLK); cyc++;
      check_idle_outputs();
      drive_junk();
    end
  endtask

  // rst_at: cycle whose edge sees RST=1 (-1 none); spur: cycle with an ignored M_EXECUTE
  task automatic run(input int rst_at, input int spur);
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge CLK); cyc++;
      if (rst_at >= 0 && i == rst_at + 1) begin
        model_dout = '0;
        check_idle_outputs();
        RST = 1'b0;
        drive_junk();
        return;
      end
      chk_eq("busy", M_BUSY, e_busy[i]);
      chk_eq("req", B_REQUEST, e_req[i]);
      chk_eq("util", B_UTIL, e_util[i]);
      chk_eq("bus_out", B_BUS_OUT, e_out[i]);
      chk_eq("dvalid", M_DVALID, e_dv[i]);
      chk_eq("err", M_ERR, e_err[i]);
      chk_eq("dout", M_DOUT, e_dout[i]);
      if (e_util[i]) chk_eq("rw", B_RW, cur_rw);
      drive_junk();
      if (i == 0) begin
        M_RW = cur_rw; M_ADDR = cur_addr; M_DIN = cur_din;
      end
      M_EXECUTE = p_exec[i] | logic'(i == spur);
      B_GRANT   = p_grant[i];
      B_ACK     = p_ack[i];
      B_BUS_IN  = p_bin[i];
      RST       = logic'(i == rst_at);
    end
  endtask

  function automatic int pick_delay();
    int sel = $urandom_range(0, 9);
    if (sel == 0) return TMO;
    if (sel == 1) return TMO - 1;
    return $urandom_range(0, 4);
  endfunction

  initial begin
    RST = 1'b1;
    drive_junk();
    repeat (3) @(negedge CLK);
    cyc = 3;
    check_idle_outputs();
    RST = 1'b0;
    idle(2);

    // directed: write, read, no grant, no address ack, boundaries, no write ack
    build(RW_WRITE, 15'h0A5A, 8'hC3, 8'h00, 2, 0, 0, 1);  run(-1, -1);  idle(1);
    build(RW_READ,  15'h0002, 8'h5A, 8'hAD, 0, 0, 0, 1);  run(-1, -1);  idle(1);
    build(RW_WRITE, 15'h1234, 8'h99, 8'h00, TMO, 0, 0, 1); run(-1, -1); idle(1);
    build(RW_WRITE, 15'h7FFF, 8'hFF, 8'h00, 0, TMO, 0, 1); run(-1, -1); idle(1);
    build(RW_READ,  15'h4001, 8'h00, 8'h3C, TMO-1, TMO-1, 0, 1); run(-1, -1); idle(1);
    build(RW_WRITE, 15'h0F0F, 8'h81, 8'h00, 1, 1, -1, 1); run(-1, -1); idle(1);

    // reset during write bit 4 (grant 0, ack 0), then a normal read
    build(RW_WRITE, 15'h2AAA, 8'hE7, 8'h00, 0, 0, 1, 1);
    run(1 + 1 + ADDR_W + 1 + 4, -1);
    idle(1);
    build(RW_READ, 15'h0155, 8'h00, 8'h6B, 1, 2, 0, 1); run(-1, -1);

    // back-to-back: write 0x11 then read, second EXECUTE right after DONE
    idle(1);
    build(RW_WRITE, 15'h0033, 8'h11, 8'h00, 0, 0, 0, 1); run(-1, 10);
    build(RW_READ,  15'h0044, 8'h00, 8'h96, 0, 0, 0, 1); run(-1, 5);
    idle(1);

    for (int t = 0; t < 40; t++) begin
      int h = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      build(rb(), ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
            pick_delay(), pick_delay(), h, $urandom_range(1, 3));
      run(-1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n_cyc - 1)) : -1);
      idle($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
